// File: rtl/audio_pkg.sv
// Shared types and helpers for the audio playback path.
package audio_pkg;

    localparam int AUDIO_DATA_W   = 8;
    localparam int AUDIO_SAMPLE_W = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } state_t;

    // Place a ROM byte in the top bits of a PDM sample, zero-filling below.
    function automatic logic [AUDIO_SAMPLE_W-1:0] msb_align(input logic [AUDIO_DATA_W-1:0] d);
        return {d, {(AUDIO_SAMPLE_W-AUDIO_DATA_W){1'b0}}};
    endfunction

endpackage

// File: rtl/rate_divider.sv
// Programmable down-counter that emits one tick every reload_i+1 enabled cycles.
module rate_divider #(
    parameter int DIV_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [DIV_W-1:0] reload_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q;

    // Load has priority; when enabled, count down and reload from reload_i at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= reload_i;
        end else if (en_i) begin
            if (cnt_q == '0) begin
                cnt_q <= reload_i;
            end else begin
                cnt_q <= cnt_q - DIV_W'(1);
            end
        end
    end

    assign tick_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/audio_rom_sequencer.sv
// Steps the sample ROM at a programmable rate and feeds MSB-aligned samples to the PDM modulator.
module audio_rom_sequencer
    import audio_pkg::*;
#(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = AUDIO_DATA_W,
    parameter int SAMPLE_W = AUDIO_SAMPLE_W,
    parameter int DIV_W    = 7
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic                pause,
    input  logic                loop_en,
    input  logic [ADDR_W-1:0]   last_adr,
    input  logic [DIV_W-1:0]    rate_div,
    output logic [ADDR_W-1:0]   rom_adr,
    input  logic [DATA_W-1:0]   rom_data,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                sample_valid,
    output logic                busy,
    output logic                done
);

    state_t              state_q;
    logic [ADDR_W-1:0]   rom_adr_q;
    logic [SAMPLE_W-1:0] sample_out_q;
    logic                sample_valid_q;
    logic                done_q;

    logic                div_load;
    logic                div_en;
    logic                tick;
    logic [SAMPLE_W-1:0] aligned;

    // The divider only advances in PLAY when no control pulse overrides the cycle.
    assign div_load = start && !stop;
    assign div_en   = (state_q == ST_PLAY) && !pause && !start && !stop;

    rate_divider #(
        .DIV_W (DIV_W)
    ) u_rate_divider (
        .clk      (clk),
        .reset    (reset),
        .load_i   (div_load),
        .en_i     (div_en),
        .reload_i (rate_div),
        .tick_o   (tick)
    );

    // Package helper covers the default widths; other widths fall back to a shift.
    if (SAMPLE_W == AUDIO_SAMPLE_W && DATA_W == AUDIO_DATA_W) begin : g_pkg_align
        assign aligned = msb_align(rom_data);
    end else begin : g_gen_align
        assign aligned = SAMPLE_W'(rom_data) << (SAMPLE_W - DATA_W);
    end

    // Playback FSM with address counter, sample register and pulse outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            rom_adr_q      <= '0;
            sample_out_q   <= '0;
            sample_valid_q <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            sample_valid_q <= 1'b0;
            done_q         <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start && !stop) begin
                        state_q   <= ST_PLAY;
                        rom_adr_q <= '0;
                    end
                end
                ST_PLAY: begin
                    if (stop) begin
                        state_q      <= ST_IDLE;
                        sample_out_q <= '0;
                        rom_adr_q    <= '0;
                    end else if (start) begin
                        rom_adr_q <= '0;
                    end else if (tick) begin
                        sample_out_q   <= aligned;
                        sample_valid_q <= 1'b1;
                        if (rom_adr_q == last_adr) begin
                            rom_adr_q <= '0;
                            if (!loop_en) begin
                                state_q <= ST_IDLE;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            rom_adr_q <= rom_adr_q + ADDR_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rom_adr      = rom_adr_q;
    assign sample_out   = sample_out_q;
    assign sample_valid = sample_valid_q;
    assign done         = done_q;
    assign busy         = (state_q != ST_IDLE);

endmodule
